ahb_decoder: RTL and testbench
==============================

# ahb_decoder

Single-layer AHB address decoder with a response multiplexer and a built-in default subordinate. It sits directly downstream of the multi-manager arbiter/mux and consumes its `mainbus` port. It fans the granted manager's address/control/write data out to `SUBORDINATES` subordinate ports, asserts one-hot `HSEL`, and returns the data-phase-selected subordinate's `HREADY`/`HRESP`/`HRDATA`. Unmapped transfers get an AHB two-cycle ERROR response.

## Interface
Parameters:
- `SUBORDINATES`, 4: number of subordinate ports (1..16).
- `BASE`, `ahb_decoder_pkg::DEFAULT_BASE`: per-subordinate 32-bit region base addresses.
- `MASK`, `ahb_decoder_pkg::DEFAULT_MASK`: per-subordinate 32-bit compare masks. Subordinate i matches when `(HADDR & MASK[i]) == BASE[i]`.

Ports:
- `HCLK`  input  1  bus clock; all state updates on its rising edge.
- `HRESET`  input  1  asynchronous, active-high reset.
- `mainbus`  ahb.subordinate  interface  upstream bus from the arbiter.
  - Decoder drives `HREADY`, `HRESP` and `HRDATA`.
- `subs[SUBORDINATES-1:0]`  ahb.manager  interface array  downstream subordinate ports.
  - Decoder drives `HADDR`, `HWDATA`, `HWRITE`, `HSIZE`, `HTRANS` and `HBURST`.
  - Decoder reads `HREADY`, `HRESP` and `HRDATA`.
- `HSEL`  output  SUBORDINATES  one-hot address-phase select, combinational from `mainbus.HADDR`.
- `hready_bus`  output  1  muxed bus `HREADY`; every subordinate samples its address phase on this.
- `err_count`  output  16  decode-error count. Present only with `AHB_DECODER_ERRCNT_EN`.

## Operation
- Address decode (combinational):
  - Each of `HSEL[i]` is asserted when `(HADDR & MASK[i]) == BASE[i]`.
  - If regions overlap, the lowest index wins, so `HSEL` is always one-hot or zero.
  - `def_sel` is asserted when no region matches.
- Broadcast: address, control and `HWDATA` go unmodified to every subordinate. Only `HSEL` distinguishes them.
- Data-phase select register `dsel` (an index plus `dsel_def` flag):
  - Loads the address-phase decode at a rising edge where `hready_bus == 1`.
  - Holds otherwise.
- Response mux:
  - `dsel_def == 0`: `mainbus.HREADY/HRESP/HRDATA` = `subs[dsel]` values.
  - `dsel_def == 1`: the default subordinate supplies the response.
  - `hready_bus` equals `mainbus.HREADY`.
- Default subordinate FSM, states `IDLE`, `ERR1`, `ERR2`:
  - `IDLE`: outputs `HREADY=1`, `HRESP=0`, `HRDATA=0`. Moves to `ERR1` when `hready_bus`, `def_sel` and `HTRANS` is NONSEQ or SEQ. Otherwise stays in `IDLE`.
  - `ERR1`: outputs `HREADY=0`, `HRESP=1`. Always moves to `ERR2`.
  - `ERR2`: outputs `HREADY=1`, `HRESP=1`. Moves to `ERR1` if another qualifying unmapped NONSEQ/SEQ is sampled this cycle, otherwise to `IDLE`.
- IDLE or BUSY transfers to unmapped space: zero-wait OKAY. `dsel_def=1`, FSM stays in `IDLE`.
- Subordinate wait states: the mux passes the selected subordinate's `HREADY=0` through, and `dsel` holds.
- A subordinate ERROR is forwarded unmodified. The decoder does not alter `HRESP` sequencing.

## Timing
- Decode to `HSEL`: 0 cycles (combinational).
- `dsel` update: 1 cycle after the address phase is accepted.
- Response path: combinational from the subordinate to `mainbus`, with no added latency.
- Unmapped NONSEQ/SEQ: exactly two data-phase cycles (`ERR1`, `ERR2`), then the next transfer's data phase.
- Reset (`HRESET=1`, asynchronous):
  - `dsel` = default with `dsel_def=1`.
  - FSM = `IDLE`.
  - `mainbus.HREADY=1`, `HRESP=0`, `HRDATA=0`.
  - `err_count=0`.
- Reset asserted mid-transfer (including in `ERR1`) forces these values immediately. There is no recovery handshake.

## Configuration
- `AHB_DECODER_ERRCNT_EN` defined:
  - `err_count` port and a 16-bit counter are present.
  - The counter increments on each `IDLE→ERR1` or `ERR2→ERR1` transition.
  - It saturates at `16'hFFFF` and is cleared only by reset.
- Macro undefined: no port and no counter. Decode and response behaviour are identical to the defined case.

## Structure
- `ahb_decoder_pkg`:
  - `htrans_t` (IDLE/BUSY/NONSEQ/SEQ).
  - `hresp_t` (OKAY/ERROR).
  - `def_state_t` (IDLE/ERR1/ERR2).
  - `DEFAULT_BASE` and `DEFAULT_MASK` (four 256 MB regions at 0x0000_0000, 0x1000_0000, 0x2000_0000, 0x3000_0000; mask 0xF000_0000).
- One sub-module, `ahb_default_sub`, holds the default-subordinate FSM and the optional error counter. Decode and mux logic stay in `ahb_decoder`.

## Test plan
- Reset release, then NONSEQ read at 0x1000_0040 with `subs[1]` returning `HRDATA=0xCAFE_F00D`:
  - `HSEL=4'b0010` in the address phase.
  - Next cycle `mainbus.HRDATA=0xCAFE_F00D`, `HRESP=OKAY`.
- Back-to-back writes to 0x0000_0000 then 0x3000_0004, with `subs[0]` inserting 2 wait states:
  - `dsel` holds 0 for 3 cycles.
  - `HSEL=4'b1000` remains asserted until `hready_bus=1`.
  - The second write completes at `subs[3]`.
- NONSEQ to unmapped 0x8000_0000:
  - Cycle 1: `HREADY=0`, `HRESP=1`.
  - Cycle 2: `HREADY=1`, `HRESP=1`.
  - `HSEL=0` throughout.
  - `err_count` goes 0→1.
- IDLE to unmapped 0x8000_0000: `HREADY=1`, `HRESP=0` with no wait; `err_count` unchanged.
- Unmapped NONSEQ in `ERR2` followed immediately by a second unmapped NONSEQ: FSM goes `ERR2→ERR1`, two complete ERROR responses, `err_count=2`.
- `HRESET` pulsed during `ERR1`: immediately `HREADY=1`, `HRESP=0`, FSM `IDLE`, `err_count=0`.

Source files
------------

// File: rtl/ahb_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_decoder_pkg
// Description : Shared types and default address map for the AHB decoder.
//               Default map is four 256 MB regions starting at 0x0000_0000,
//               0x1000_0000, 0x2000_0000 and 0x3000_0000.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_decoder_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_t;

    // Element [i] belongs to subordinate i.
    localparam logic [3:0][31:0] DEFAULT_BASE = {
        32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [3:0][31:0] DEFAULT_MASK = {4{32'hF000_0000}};

    // NONSEQ and SEQ carry data; IDLE and BUSY do not.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb
// Description : AHB bus bundle. The manager modport drives address, control
//               and write data; the subordinate modport drives the response.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic        HRESP;

    modport manager (
        output HADDR, HWDATA, HWRITE, HSIZE, HTRANS, HBURST,
        input  HREADY, HRESP, HRDATA
    );

    modport subordinate (
        input  HADDR, HWDATA, HWRITE, HSIZE, HTRANS, HBURST,
        output HREADY, HRESP, HRDATA
    );
endinterface
`default_nettype wire

// File: rtl/ahb_default_sub.sv
`default_nettype none
// ============================================================================
// Module      : ahb_default_sub
// Description : Default subordinate answering transfers that hit no mapped
//               region. Active transfers get the two-cycle AHB ERROR
//               response; IDLE/BUSY transfers get a zero-wait OKAY.
//               With AHB_DECODER_ERRCNT_EN defined, a saturating 16-bit
//               count of error responses started is also kept.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_hready_bus    - bus HREADY (address phase accepted)
//               i_def_sel       - current address decodes to no region
//               i_htrans        - current address-phase HTRANS
//               o_hready/o_hresp- default-subordinate response
//               o_err_count     - error count (AHB_DECODER_ERRCNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_default_sub
    import ahb_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hready_bus,
    input  logic        i_def_sel,
    input  logic [1:0]  i_htrans,
    output logic        o_hready,
    output logic        o_hresp
`ifdef AHB_DECODER_ERRCNT_EN
    ,
    output logic [15:0] o_err_count
`endif
);

    def_state_t r_state;
    def_state_t w_state_d;
    logic       w_err_start;

    // An unmapped active transfer being accepted this cycle.
    assign w_err_start = i_hready_bus && i_def_sel && is_active(i_htrans);

    // Next-state logic kept apart from the output decode so the outputs
    // depend on the state only and never loop back through i_hready_bus.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            DEF_IDLE: if (w_err_start) w_state_d = DEF_ERR1;
            DEF_ERR1: w_state_d = DEF_ERR2;
            DEF_ERR2: w_state_d = w_err_start ? DEF_ERR1 : DEF_IDLE;
            default:  w_state_d = DEF_IDLE;
        endcase
    end

    always_comb begin
        o_hready = 1'b1;
        o_hresp  = HRESP_OKAY;
        case (r_state)
            DEF_ERR1: begin
                o_hready = 1'b0;
                o_hresp  = HRESP_ERROR;
            end
            DEF_ERR2: begin
                o_hready = 1'b1;
                o_hresp  = HRESP_ERROR;
            end
            default: begin
                o_hready = 1'b1;
                o_hresp  = HRESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEF_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

`ifdef AHB_DECODER_ERRCNT_EN
    logic [15:0] r_err_count;

    // Every entry into ERR1 starts a new error response; ERR1 is never
    // re-entered from itself, so excluding it avoids double counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 16'd0;
        end else if (w_err_start && (r_state != DEF_ERR1) &&
                     (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign o_err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: rtl/ahb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_decoder
// Description : Single-layer AHB address decoder and response multiplexer.
//               Broadcasts the upstream address/control/write data to every
//               subordinate, raises a one-hot HSEL (lowest index wins on
//               overlap) and returns the response of the subordinate owning
//               the current data phase. Unmapped space is answered by
//               ahb_default_sub.
//               Optional feature macro: AHB_DECODER_ERRCNT_EN adds the
//               err_count output.
// Ports       : HCLK, HRESET    - clock, asynchronous active-high reset
//               mainbus         - upstream bus (decoder returns response)
//               subs[]          - downstream subordinate buses
//               HSEL            - one-hot address-phase select
//               hready_bus      - muxed HREADY seen by all subordinates
//               err_count       - decode-error count (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_decoder
    import ahb_decoder_pkg::*;
#(
    parameter int                            SUBORDINATES = 4,
    parameter logic [SUBORDINATES-1:0][31:0] BASE         = DEFAULT_BASE,
    parameter logic [SUBORDINATES-1:0][31:0] MASK         = DEFAULT_MASK
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    ahb.subordinate                 mainbus,
    ahb.manager                     subs [SUBORDINATES-1:0],
    output logic [SUBORDINATES-1:0] HSEL,
    output logic                    hready_bus
`ifdef AHB_DECODER_ERRCNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    localparam int c_IDX_W = (SUBORDINATES > 1) ? $clog2(SUBORDINATES) : 1;

    logic [c_IDX_W-1:0] w_addr_idx;
    logic               w_def_sel;
    logic [c_IDX_W-1:0] r_dsel_idx;
    logic               r_dsel_def;

    logic               w_sub_hready [SUBORDINATES];
    logic               w_sub_hresp  [SUBORDINATES];
    logic [31:0]        w_sub_hrdata [SUBORDINATES];

    logic               w_def_hready;
    logic               w_def_hresp;

    logic               w_hready;
    logic               w_hresp;
    logic [31:0]        w_hrdata;

    // ------------------------------------------------------------------
    // Address decode. Scanning from the top index down lets the lowest
    // matching index overwrite any higher one, keeping HSEL one-hot.
    // ------------------------------------------------------------------
    always_comb begin
        HSEL       = '0;
        w_addr_idx = '0;
        w_def_sel  = 1'b1;
        for (int i = SUBORDINATES - 1; i >= 0; i--) begin
            if ((mainbus.HADDR & MASK[i]) == BASE[i]) begin
                HSEL       = '0;
                HSEL[i]    = 1'b1;
                w_addr_idx = c_IDX_W'(i);
                w_def_sel  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Broadcast and response capture per subordinate port.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < SUBORDINATES; g++) begin : g_sub
        assign subs[g].HADDR   = mainbus.HADDR;
        assign subs[g].HWDATA  = mainbus.HWDATA;
        assign subs[g].HWRITE  = mainbus.HWRITE;
        assign subs[g].HSIZE   = mainbus.HSIZE;
        assign subs[g].HTRANS  = mainbus.HTRANS;
        assign subs[g].HBURST  = mainbus.HBURST;

        assign w_sub_hready[g] = subs[g].HREADY;
        assign w_sub_hresp[g]  = subs[g].HRESP;
        assign w_sub_hrdata[g] = subs[g].HRDATA;
    end

    // ------------------------------------------------------------------
    // Data-phase owner: captured whenever an address phase is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dsel_idx <= '0;
            r_dsel_def <= 1'b1;
        end else if (w_hready) begin
            r_dsel_idx <= w_addr_idx;
            r_dsel_def <= w_def_sel;
        end
    end

    // ------------------------------------------------------------------
    // Response multiplexer.
    // ------------------------------------------------------------------
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        w_hrdata = '0;
        if (r_dsel_def) begin
            w_hready = w_def_hready;
            w_hresp  = w_def_hresp;
        end else begin
            w_hready = w_sub_hready[r_dsel_idx];
            w_hresp  = w_sub_hresp[r_dsel_idx];
            w_hrdata = w_sub_hrdata[r_dsel_idx];
        end
    end

    assign mainbus.HREADY = w_hready;
    assign mainbus.HRESP  = w_hresp;
    assign mainbus.HRDATA = w_hrdata;
    assign hready_bus     = w_hready;

    // ------------------------------------------------------------------
    // Default subordinate.
    // ------------------------------------------------------------------
    ahb_default_sub u_default_sub (
        .clk          (HCLK),
        .rst          (HRESET),
        .i_hready_bus (w_hready),
        .i_def_sel    (w_def_sel),
        .i_htrans     (mainbus.HTRANS),
        .o_hready     (w_def_hready),
        .o_hresp      (w_def_hresp)
`ifdef AHB_DECODER_ERRCNT_EN
        ,
        .o_err_count  (err_count)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_decoder
// Description : Self-checking bench for ahb_decoder. Directed scenarios pin
//               literal values; a randomized phase is checked every cycle
//               against a transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  hsel;
    logic        hready_bus;
`ifdef AHB_DECODER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ahb mbus ();
    ahb sbus [3:0] ();

    ahb_decoder #(.SUBORDINATES(4)) u_dut (
        .HCLK       (clk),
        .HRESET     (rst),
        .mainbus    (mbus),
        .subs       (sbus),
        .HSEL       (hsel),
        .hready_bus (hready_bus)
`ifdef AHB_DECODER_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Subordinate models: configurable wait states, address-derived data.
    // ------------------------------------------------------------------
    int          wait_cfg  [4];
    int          sm_wait   [4];
    logic [31:0] sm_rdata  [4];
    logic        sm_resp   [4];
    int          sm_wr_cnt [4];
    logic        err_en = 1'b0;

    logic [31:0] s_haddr  [4];
    logic [31:0] s_hwdata [4];
    logic [10:0] s_ctrl   [4];
    logic        s_hready [4];
    logic        s_hresp  [4];
    logic [31:0] s_hrdata [4];

    for (genvar g = 0; g < 4; g++) begin : g_sub
        assign sbus[g].HREADY = (sm_wait[g] == 0);
        assign sbus[g].HRESP  = sm_resp[g];
        assign sbus[g].HRDATA = sm_rdata[g];
        assign s_haddr[g]  = sbus[g].HADDR;
        assign s_hwdata[g] = sbus[g].HWDATA;
        assign s_ctrl[g]   = {sbus[g].HWRITE, sbus[g].HSIZE, sbus[g].HTRANS,
                              sbus[g].HBURST, 2'b00};
        assign s_hready[g] = sbus[g].HREADY;
        assign s_hresp[g]  = sbus[g].HRESP;
        assign s_hrdata[g] = sbus[g].HRDATA;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                sm_wait[k]  <= 0;
                sm_rdata[k] <= '0;
                sm_resp[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (hready_bus && hsel[k] && mbus.HTRANS[1]) begin
                    sm_wait[k]  <= wait_cfg[k];
                    sm_rdata[k] <= (mbus.HADDR == 32'h1000_0040) ? 32'hCAFE_F00D
                                   : ((mbus.HADDR ^ 32'h5A5A_0000) + 32'(k));
                    sm_resp[k]  <= err_en && mbus.HADDR[3];
                    if (mbus.HWRITE) sm_wr_cnt[k] <= sm_wr_cnt[k] + 1;
                end else if (sm_wait[k] > 0) begin
                    sm_wait[k] <= sm_wait[k] - 1;
                end else begin
                    sm_resp[k] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: who owns the data phase, and where an error
    // response is in its two cycles.
    // kind 0 = zero-wait OKAY, 1 = mapped subordinate, 2 = ERROR response
    // ------------------------------------------------------------------
    int          m_kind, m_sub, m_errcyc, m_errcnt, m_dec;
    logic        exp_ready, exp_resp;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_hsel;

    // Regions are the 256 MB blocks whose top nibble is 0..3.
    always_comb begin
        m_dec    = (mbus.HADDR[31:28] < 4'd4) ? int'(mbus.HADDR[31:28]) : -1;
        exp_hsel = (m_dec >= 0) ? 4'(1 << m_dec) : 4'b0000;
    end

    always_comb begin
        exp_ready = 1'b1;
        exp_resp  = 1'b0;
        exp_rdata = '0;
        if (m_kind == 1) begin
            exp_ready = s_hready[m_sub];
            exp_resp  = s_hresp[m_sub];
            exp_rdata = s_hrdata[m_sub];
        end else if (m_kind == 2) begin
            exp_ready = (m_errcyc == 1);
            exp_resp  = 1'b1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_kind   <= 0;
            m_sub    <= 0;
            m_errcyc <= 0;
            m_errcnt <= 0;
        end else if (exp_ready) begin
            if (m_dec >= 0) begin
                m_kind <= 1;
                m_sub  <= m_dec;
            end else if (mbus.HTRANS[1]) begin
                m_kind   <= 2;
                m_errcyc <= 0;
                if (m_errcnt < 65535) m_errcnt <= m_errcnt + 1;
            end else begin
                m_kind <= 0;
            end
        end else if (m_kind == 2) begin
            m_errcyc <= 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_hsel",   32'(hsel), 32'(exp_hsel));
            chk("m_hready", 32'(mbus.HREADY), 32'(exp_ready));
            chk("m_hrbus",  32'(hready_bus), 32'(exp_ready));
            chk("m_hresp",  32'(mbus.HRESP), 32'(exp_resp));
            chk("m_hrdata", mbus.HRDATA, exp_rdata);
`ifdef AHB_DECODER_ERRCNT_EN
            chk("m_errcnt", 32'(err_count), 32'(m_errcnt));
`endif
            for (int k = 0; k < 4; k++) begin
                chk("bc_haddr",  s_haddr[k], mbus.HADDR);
                chk("bc_hwdata", s_hwdata[k], mbus.HWDATA);
                chk("bc_ctrl",   32'(s_ctrl[k]), 32'({mbus.HWRITE, mbus.HSIZE,
                                    mbus.HTRANS, mbus.HBURST, 2'b00}));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers.
    // ------------------------------------------------------------------
    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
        mbus.HADDR  = a;
        mbus.HTRANS = t;
        mbus.HWRITE = w;
        mbus.HWDATA = $urandom;
        mbus.HSIZE  = 3'($urandom_range(0, 2));
        mbus.HBURST = 3'($urandom_range(0, 7));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 2'b00, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_rsp(input string name, input logic rdy, input logic rsp);
        chk({name, "_rdy"}, 32'(mbus.HREADY), 32'(rdy));
        chk({name, "_rsp"}, 32'(mbus.HRESP), 32'(rsp));
    endtask

    // Presents one address phase and holds it until accepted.
    task automatic xfer(input logic [31:0] a, input logic [1:0] t, input logic w);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        drive(a, t, w);
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = hready_bus;
            step();
            n++;
        end
        if (!acc) chk("xfer_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_wr;
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            wait_cfg[k]  = 0;
            sm_wr_cnt[k] = 0;
        end
        do_reset();

        // Reset values.
        @(negedge clk);
        chk_rsp("rst", 1'b1, 1'b0);
        chk("rst_rdata", mbus.HRDATA, 32'h0);

        // Read from subordinate 1.
        step();
        drive(32'h1000_0040, 2'b10, 1'b0);
        @(negedge clk);
        chk("t1_hsel", 32'(hsel), 32'h2);
        step();
        drive(32'h0, 2'b00, 1'b0);
        @(negedge clk);
        chk("t1_rdata", mbus.HRDATA, 32'hCAFE_F00D);
        chk_rsp("t1", 1'b1, 1'b0);

        // Back-to-back writes, subordinate 0 inserting two wait states.
        wait_cfg[0] = 2;
        prev_wr     = sm_wr_cnt[3];
        step();
        drive(32'h0000_0000, 2'b10, 1'b1);
        @(negedge clk);
        chk("t2_hsel0", 32'(hsel), 32'h1);
        step();
        drive(32'h3000_0004, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hsel3", 32'(hsel), 32'h8);
            chk("t2_hrbus", 32'(hready_bus), (i == 2) ? 32'd1 : 32'd0);
            if (i < 2) step();
        end
        step();
        drive(32'h3000_0004, 2'b00, 1'b0);
        @(negedge clk);
        chk_rsp("t2_w2", 1'b1, 1'b0);
        chk("t2_sub3_wr", 32'(sm_wr_cnt[3]), 32'(prev_wr + 1));
        wait_cfg[0] = 0;

        // Unmapped NONSEQ, then an unmapped IDLE.
        step();
        drive(32'h8000_0000, 2'b10, 1'b0);
        @(negedge clk);
        chk("t3_hsel_a", 32'(hsel), 32'h0);
        step();
        drive(32'h8000_0000, 2'b00, 1'b0);
        @(negedge clk);
        chk_rsp("t3_c1", 1'b0, 1'b1);
        chk("t3_hsel_1", 32'(hsel), 32'h0);
        step();
        @(negedge clk);
        chk_rsp("t3_c2", 1'b1, 1'b1);
        chk("t3_hsel_2", 32'(hsel), 32'h0);
`ifdef AHB_DECODER_ERRCNT_EN
        chk("t3_errcnt", 32'(err_count), 32'd1);
`endif
        step();
        @(negedge clk);
        chk_rsp("t4_idle", 1'b1, 1'b0);
`ifdef AHB_DECODER_ERRCNT_EN
        chk("t4_errcnt", 32'(err_count), 32'd1);
`endif

        // Second unmapped NONSEQ sampled in ERR2.
        do_reset();
        drive(32'h8000_0000, 2'b10, 1'b0);
        step();
        @(negedge clk);
        chk_rsp("t5_a1", 1'b0, 1'b1);
        step();
        @(negedge clk);
        chk_rsp("t5_a2", 1'b1, 1'b1);
        step();
        drive(32'h8000_0000, 2'b00, 1'b0);
        @(negedge clk);
        chk_rsp("t5_b1", 1'b0, 1'b1);
        step();
        @(negedge clk);
        chk_rsp("t5_b2", 1'b1, 1'b1);
        step();
        @(negedge clk);
        chk_rsp("t5_end", 1'b1, 1'b0);
`ifdef AHB_DECODER_ERRCNT_EN
        chk("t5_errcnt", 32'(err_count), 32'd2);
`endif

        // Reset pulsed while in ERR1.
        step();
        drive(32'h8000_0000, 2'b10, 1'b0);
        step();
        drive(32'h8000_0000, 2'b00, 1'b0);
        @(negedge clk);
        chk_rsp("t6_err1", 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_rsp("t6_rst", 1'b1, 1'b0);
        chk("t6_rdata", mbus.HRDATA, 32'h0);
`ifdef AHB_DECODER_ERRCNT_EN
        chk("t6_errcnt", 32'(err_count), 32'd0);
`endif
        step();
        rst = 1'b0;

        // Randomized traffic across mapped and unmapped space.
        err_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) wait_cfg[k] = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[31:28] = 4'($urandom_range(0, 3));
            xfer(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        xfer(32'h0, 2'b00, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
